multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the single-issue MIPS datapath: fetch, decoder enable,
//  ALU, memory, register write-back and PC update. Chooses each instruction's stage sequence from
//  the decoder's registered path_index and provides the global busy/halted status for the top level.

---
 rtl/multicycle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the single-issue MIPS datapath: walks each instruction through
// fetch/decode/exec/mem/wb/pc-update and reports busy/halted status. All outputs are registered.
module multicycle_sequencer #(
    parameter int unsigned MEM_LAT       = 2,
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             decoder_done,
    input  logic [3:0]       path_index,
    input  logic             alu_zero,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             alu_en,
    output logic             mem_en,
    output logic             reg_write_en,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned MaxLat = (MEM_LAT > MULDIV_CYCLES) ? MEM_LAT : MULDIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLat) + 1;

    localparam logic [3:0] PathMf   = 4'b0000;
    localparam logic [3:0] PathAlu  = 4'b0001;
    localparam logic [3:0] PathLw   = 4'b0010;
    localparam logic [3:0] PathSw   = 4'b0011;
    localparam logic [3:0] PathBeq  = 4'b0100;
    localparam logic [3:0] PathJ    = 4'b0101;
    localparam logic [3:0] PathJal  = 4'b0110;
    localparam logic [3:0] PathMul  = 4'b0111;
    localparam logic [3:0] PathJr   = 4'b1000;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StDecWait = 4'd3,
        StExec    = 4'd4,
        StMem     = 4'd5,
        StWb      = 4'd6,
        StPcUpd   = 4'd7,
        StHalt    = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        path_q, path_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        pc_sel_d;

    assign state_out   = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

    always_comb begin
        state_d     = state_q;
        path_d      = path_q;
        cnt_d       = cnt_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        count_d     = count_q;
        halt_pend_d = halt_pend_q | halt_req;

        case (state_q)
            StIdle: begin
                if (halt_req || halt_pend_q) state_d = StHalt;
                else if (start)              state_d = StFetch;
            end
            StFetch:  state_d = StDecode;
            StDecode: state_d = StDecWait;
            StDecWait: begin
                if (decoder_done) begin
                    path_d = path_index;
                    cnt_d  = '0;
                    unique case (path_index)
                        PathMf, PathJal:                 state_d = StWb;
                        PathAlu, PathLw, PathSw, PathBeq: state_d = StExec;
                        PathMul: begin
                            state_d = StExec;
                            cnt_d   = CntW'(MULDIV_CYCLES - 1);
                        end
                        PathJ, PathJr:                   state_d = StPcUpd;
                        default: begin
                            state_d   = StHalt;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    taken_d = (path_q == PathBeq) && alu_zero;
                    if (path_q == PathAlu) begin
                        state_d = StWb;
                    end else if (path_q == PathLw || path_q == PathSw) begin
                        state_d = StMem;
                        cnt_d   = CntW'(MEM_LAT - 1);
                    end else begin
                        state_d = StPcUpd;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StMem: begin
                if (cnt_q == '0) state_d = (path_q == PathLw) ? StWb : StPcUpd;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StWb: state_d = StPcUpd;
            StPcUpd: begin
                count_d = count_q + CNT_W'(1);
                state_d = (halt_pend_q || halt_req) ? StHalt : StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase

        if (state_d == StHalt) halt_pend_d = 1'b0;

        // pc_sel is registered alongside the strobes, so it is chosen from next-state values.
        pc_sel_d = 2'b00;
        if (state_d == StPcUpd) begin
            case (path_d)
                PathBeq:       pc_sel_d = taken_d ? 2'b01 : 2'b00;
                PathJ, PathJal: pc_sel_d = 2'b10;
                PathJr:        pc_sel_d = 2'b11;
                default:       pc_sel_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            path_q       <= '0;
            cnt_q        <= '0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            halt_pend_q  <= 1'b0;
            count_q      <= '0;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            alu_en       <= 1'b0;
            mem_en       <= 1'b0;
            reg_write_en <= 1'b0;
            pc_en        <= 1'b0;
            pc_sel       <= 2'b00;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state_q      <= state_d;
            path_q       <= path_d;
            cnt_q        <= cnt_d;
            taken_q      <= taken_d;
            illegal_q    <= illegal_d;
            halt_pend_q  <= halt_pend_d;
            count_q      <= count_d;
            fetch_en     <= (state_d == StFetch);
            decode_en    <= (state_d == StDecode);
            alu_en       <= (state_d == StExec);
            mem_en       <= (state_d == StMem);
            reg_write_en <= (state_d == StWb);
            pc_en        <= (state_d == StPcUpd);
            pc_sel       <= pc_sel_d;
            busy         <= (state_d != StIdle) && (state_d != StHalt);
            halted       <= (state_d == StHalt);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench: each instruction is expanded into its expected per-cycle
// stage list and compared against the sequencer's registered outputs every cycle.
module tb_multicycle_sequencer;

    localparam int MemLat = 2;
    localparam int MulDiv = 4;
    localparam int CntW   = 4;

    localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SDecWait = 4'd3;
    localparam logic [3:0] SExec = 4'd4, SMem = 4'd5, SWb = 4'd6, SPcUpd = 4'd7, SHalt = 4'd8;

    logic            clk = 1'b0;
    logic            rst, start, halt_req, decoder_done, alu_zero;
    logic [3:0]      path_index;
    logic            fetch_en, decode_en, alu_en, mem_en, reg_write_en, pc_en;
    logic [1:0]      pc_sel;
    logic            busy, halted, illegal;
    logic [3:0]      state_out;
    logic [CntW-1:0] instr_count;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] sel;
        logic       dd;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count = 0;
    logic exp_illegal = 1'b0;

    multicycle_sequencer #(
        .MEM_LAT      (MemLat),
        .MULDIV_CYCLES(MulDiv),
        .CNT_W        (CntW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .decoder_done(decoder_done),
        .path_index  (path_index),
        .alu_zero    (alu_zero),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .alu_en      (alu_en),
        .mem_en      (mem_en),
        .reg_write_en(reg_write_en),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .state_out   (state_out),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One-hot strobe pattern {fetch,decode,alu,mem,wb,pc} each stage asserts.
    function automatic logic [5:0] strobes_of(input logic [3:0] st);
        case (st)
            SFetch:  return 6'b100000;
            SDecode: return 6'b010000;
            SExec:   return 6'b001000;
            SMem:    return 6'b000100;
            SWb:     return 6'b000010;
            SPcUpd:  return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [14:0] observed();
        return {state_out, fetch_en, decode_en, alu_en, mem_en, reg_write_en, pc_en, pc_sel,
                busy, halted, illegal};
    endfunction

    task automatic add(input logic [3:0] st, input int n, input logic [1:0] sel,
                       input logic dd);
        cyc_t c;
        c.st  = st;
        c.sel = sel;
        c.dd  = dd;
        for (int k = 0; k < n; k++) exp_q.push_back(c);
    endtask

    task automatic build(input logic [3:0] path, input logic az, input int waits);
        exp_q.delete();
        add(SFetch, 1, 2'b00, 1'b0);
        add(SDecode, 1, 2'b00, 1'b0);
        add(SDecWait, waits, 2'b00, 1'b0);
        add(SDecWait, 1, 2'b00, 1'b1);
        case (path)
            4'b0000: begin add(SWb, 1, 2'b00, 1'b0); add(SPcUpd, 1, 2'b00, 1'b0); end
            4'b0001: begin
                add(SExec, 1, 2'b00, 1'b0); add(SWb, 1, 2'b00, 1'b0);
                add(SPcUpd, 1, 2'b00, 1'b0);
            end
            4'b0010: begin
                add(SExec, 1, 2'b00, 1'b0); add(SMem, MemLat, 2'b00, 1'b0);
                add(SWb, 1, 2'b00, 1'b0); add(SPcUpd, 1, 2'b00, 1'b0);
            end
            4'b0011: begin
                add(SExec, 1, 2'b00, 1'b0); add(SMem, MemLat, 2'b00, 1'b0);
                add(SPcUpd, 1, 2'b00, 1'b0);
            end
            4'b0100: begin
                add(SExec, 1, 2'b00, 1'b0); add(SPcUpd, 1, az ? 2'b01 : 2'b00, 1'b0);
            end
            4'b0101: add(SPcUpd, 1, 2'b10, 1'b0);
            4'b0110: begin add(SWb, 1, 2'b00, 1'b0); add(SPcUpd, 1, 2'b10, 1'b0); end
            4'b0111: begin add(SExec, MulDiv, 2'b00, 1'b0); add(SPcUpd, 1, 2'b00, 1'b0); end
            4'b1000: add(SPcUpd, 1, 2'b11, 1'b0);
            default: ;
        endcase
    endtask

    // Called at a negedge where the DUT shows FETCH; returns at the negedge after the last stage.
    task automatic run_instr(input logic [3:0] path, input logic az, input int waits,
                             input int halt_at, input int abort_at);
        build(path, az, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc_t e;
            e = exp_q[i];
            decoder_done = e.dd;
            path_index   = e.dd ? path : 4'($urandom);
            alu_zero     = (e.st == SExec) ? az : 1'($urandom);
            start        = 1'($urandom);
            halt_req     = (i == halt_at);
            rst          = (i == abort_at);
            check_eq("stage", 64'(observed()),
                     64'({e.st, strobes_of(e.st), e.sel, 1'b1, 1'b0, exp_illegal}));
            check_eq("instr_count", 64'(instr_count), 64'(exp_count));
            if (e.st == SPcUpd && i != abort_at) exp_count = (exp_count + 1) % (1 << CntW);
            @(negedge clk);
            if (i == abort_at) begin
                rst = 1'b0;
                exp_count = 0;
                exp_illegal = 1'b0;
                break;
            end
        end
        decoder_done = 1'b0;
        halt_req     = 1'b0;
        start        = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq(tag, 64'(observed()), 64'({SIdle, 6'b0, 2'b00, 1'b0, 1'b0, 1'b0}));
        check_eq({tag, "_count"}, 64'(instr_count), 64'(0));
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'($urandom);
            halt_req = 1'($urandom);
            check_eq("halt", 64'(observed()),
                     64'({SHalt, 6'b0, 2'b00, 1'b0, 1'b1, exp_illegal}));
            check_eq("halt_count", 64'(instr_count), 64'(exp_count));
            @(negedge clk);
        end
        start    = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_count   = 0;
        exp_illegal = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; decoder_done = 1'b0;
        alu_zero = 1'b0; path_index = 4'b0;
        do_reset();
        check_idle("reset");
        @(negedge clk);
        check_idle("idle_hold");
        kick();

        run_instr(4'b0001, 1'b0, 0, -1, -1);
        run_instr(4'b0010, 1'b0, 0, -1, -1);
        run_instr(4'b0011, 1'b1, 2, -1, -1);
        run_instr(4'b0100, 1'b1, 0, -1, -1);
        run_instr(4'b0100, 1'b0, 1, -1, -1);
        run_instr(4'b0111, 1'b1, 0, -1, -1);
        run_instr(4'b1000, 1'b0, 0, -1, -1);
        run_instr(4'b0110, 1'b0, 3, -1, -1);
        run_instr(4'b0101, 1'b1, 0, -1, -1);
        run_instr(4'b0000, 1'b0, 0, -1, -1);
        repeat (30) begin
            run_instr(4'($urandom_range(0, 8)), 1'($urandom), int'($urandom_range(0, 3)), -1, -1);
        end

        // halt_req pulse in the first EXEC cycle of a mult/div: instruction still retires.
        run_instr(4'b0111, 1'b0, 0, 3, -1);
        check_halt(4);

        do_reset();
        check_idle("reset2");
        kick();
        run_instr(4'b1111, 1'b0, 1, -1, -1);
        exp_illegal = 1'b1;
        check_halt(5);

        do_reset();
        check_idle("reset3");
        kick();
        run_instr(4'b0001, 1'b0, 0, -1, -1);
        run_instr(4'b0010, 1'b0, 0, -1, 4);
        check_idle("abort_mem");

        halt_req = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        start    = 1'b0;
        check_halt(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
